// File: rtl/ad5681r_pkg.sv
// Shared constants, state encoding and frame helper for the AD5681R DAC driver.
package ad5681r_pkg;

  localparam int unsigned FRAME_W = 24;

  localparam logic [3:0] CMD_WR_UPD  = 4'b0011;
  localparam logic [3:0] CMD_WR_CTRL = 4'b0100;

  // Control word: reset=0, PD=00, internal reference on, gain x1
  localparam logic [FRAME_W-1:0] CTRL_DEFAULT = {CMD_WR_CTRL, 20'h00000};

  typedef logic [2:0] state_t;

  localparam state_t ST_RST_PULSE = 3'd0;
  localparam state_t ST_RST_WAIT  = 3'd1;
  localparam state_t ST_CTRL_LOAD = 3'd2;
  localparam state_t ST_IDLE      = 3'd3;
  localparam state_t ST_LOAD      = 3'd4;
  localparam state_t ST_SHIFT     = 3'd5;
  localparam state_t ST_GAP       = 3'd6;

  function automatic logic [FRAME_W-1:0] upd_frame(input logic [11:0] code);
    return {CMD_WR_UPD, code, 8'h00};
  endfunction

endpackage

// File: rtl/ad5681r_spi_shift.sv
// Loadable 24-bit MSB-first shifter generating SCL (idle high) and SDA; the DAC
// samples SDA on SCL falling edges.
module ad5681r_spi_shift
  import ad5681r_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               scl_o,
  output logic               sda_o,
  output logic               done_o
);

  localparam int unsigned PhW = $clog2(2 * CLK_DIV);
  localparam logic [PhW-1:0] PhFall = PhW'(CLK_DIV - 1);
  localparam logic [PhW-1:0] PhLast = PhW'(2 * CLK_DIV - 1);
  localparam logic [4:0]     BitLast = 5'(FRAME_W - 1);

  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [4:0]         bit_q, bit_d;
  logic [PhW-1:0]     ph_q, ph_d;
  logic               act_q, act_d;
  logic               scl_q, scl_d;
  logic               sda_q, sda_d;

  always_comb begin
    sr_d  = sr_q;
    bit_d = bit_q;
    ph_d  = ph_q;
    act_d = act_q;
    scl_d = scl_q;
    sda_d = sda_q;
    if (load_i) begin
      sr_d  = frame_i;
      bit_d = '0;
      ph_d  = '0;
      act_d = 1'b1;
      scl_d = 1'b1;
      sda_d = frame_i[FRAME_W-1];
    end else if (act_q) begin
      if (ph_q == PhLast) begin
        ph_d  = '0;
        scl_d = 1'b1;
        if (bit_q == BitLast) begin
          // Frame end: counters wrap and the line returns to idle
          bit_d = '0;
          act_d = 1'b0;
          sda_d = 1'b0;
        end else begin
          bit_d = bit_q + 5'd1;
          sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
          sda_d = sr_q[FRAME_W-2];
        end
      end else begin
        ph_d = ph_q + PhW'(1);
        if (ph_q == PhFall) begin
          scl_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      bit_q <= '0;
      ph_q  <= '0;
      act_q <= 1'b0;
      scl_q <= 1'b1;
      sda_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      bit_q <= bit_d;
      ph_q  <= ph_d;
      act_q <= act_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_o  = scl_q;
  assign sda_o  = sda_q;
  assign done_o = act_q && (bit_q == BitLast) && (ph_q == PhLast);

endmodule

// File: rtl/ad5681r_dac_drv.sv
// AD5681R serial driver: hardware-reset pulse and control write after reset,
// then one write-and-update frame per accepted 12-bit sample.
module ad5681r_dac_drv
  import ad5681r_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned RST_CYC   = 32,
  parameter int unsigned INIT_WAIT = 50,
  parameter int unsigned SYNC_HI   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        busy_o,
  output logic        AD5681R_SCL,
  output logic        AD5681R_SDA,
  output logic        AD5681R_SYNCn,
  output logic        AD5681R_RSTn,
  output logic        AD5681R_LDACn
);

  localparam int unsigned CntMax0 = (RST_CYC > INIT_WAIT) ? RST_CYC : INIT_WAIT;
  localparam int unsigned CntMax  = (CntMax0 > SYNC_HI) ? CntMax0 : SYNC_HI;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              syncn_q, syncn_d;
  logic              rstn_q, rstn_d;
  logic              load;
  logic [FRAME_W-1:0] frame;
  logic              shift_done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    frame   = CTRL_DEFAULT;
    case (state_q)
      ST_RST_PULSE: begin
        if (cnt_q == CntW'(RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_RST_WAIT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == CntW'(INIT_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = ST_CTRL_LOAD;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_CTRL_LOAD: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_IDLE: begin
        // The shifter latches the frame, so sample_i matters only on this edge
        if (sample_valid_i && ready_q) begin
          load    = 1'b1;
          frame   = upd_frame(sample_i);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == CntW'(SYNC_HI - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_RST_PULSE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    syncn_d = !((state_d == ST_LOAD) || (state_d == ST_SHIFT));
    rstn_d  = (state_d != ST_RST_PULSE);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST_PULSE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      syncn_q <= 1'b1;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      syncn_q <= syncn_d;
      rstn_q  <= rstn_d;
    end
  end

  ad5681r_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .frame_i (frame),
    .scl_o   (AD5681R_SCL),
    .sda_o   (AD5681R_SDA),
    .done_o  (shift_done)
  );

  assign sample_ready_o = ready_q;
  assign busy_o         = busy_q;
  assign AD5681R_SYNCn  = syncn_q;
  assign AD5681R_RSTn   = rstn_q;
  assign AD5681R_LDACn  = 1'b0;

endmodule
